// File: rtl/im_loader.sv
// Boot-time instruction memory programmer: assembles a length-prefixed, big-endian
// byte stream into 16-bit words. Optional trailing checksum byte: IM_LOADER_CKSUM_EN.
module im_loader #(
  parameter int          ADDR_W    = 14,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_byte,
  input  logic        rx_vld,
  output logic        im_we,
  output logic [15:0] im_waddr,
  output logic [15:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  localparam int                TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE_W    = BASE_ADDR[ADDR_W-1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_D_HI, S_D_LO, S_WR, S_FIN
`ifdef IM_LOADER_CKSUM_EN
    , S_CK
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [16:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;
  logic [TW-1:0]     tmo_q, tmo_d;
`ifdef IM_LOADER_CKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  logic        waiting, tmo_hit, fin_ok, fin_bad;
  logic [15:0] len_w;

  // States that are waiting on the UART and therefore covered by the timeout.
  assign waiting = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                   (state_q == S_D_HI)   || (state_q == S_D_LO)
`ifdef IM_LOADER_CKSUM_EN
                   || (state_q == S_CK)
`endif
                   ;
  assign len_w = {len_hi_q, rx_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_hi_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_W;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= 1'b1;
      tmo_q    <= '0;
`ifdef IM_LOADER_CKSUM_EN
      cksum_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
`ifdef IM_LOADER_CKSUM_EN
      cksum_q  <= cksum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    hold_d   = hold_q;
    tmo_d    = '0;
    tmo_hit  = 1'b0;
    fin_ok   = 1'b0;
    fin_bad  = 1'b0;
`ifdef IM_LOADER_CKSUM_EN
    cksum_d  = cksum_q;
    if (rx_vld && waiting && (state_q != S_CK))
      cksum_d = cksum_q + rx_byte;
`endif

    // Idle-gap counter: cleared by any byte, expires after TIMEOUT silent cycles.
    if (waiting) begin
      if (rx_vld)                tmo_d   = '0;
      else if (tmo_q == TMO_LAST) tmo_hit = 1'b1;
      else                       tmo_d   = tmo_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          addr_d  = BASE_W;
`ifdef IM_LOADER_CKSUM_EN
          cksum_d = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (rx_vld) begin
          len_hi_d = rx_byte;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rx_vld) begin
          if (len_w == 16'd0)                  fin_ok  = 1'b1;
          else if ({1'b0, len_w} > MAX_WORDS)  fin_bad = 1'b1;
          else begin
            cnt_d   = {1'b0, len_w};
            state_d = S_D_HI;
          end
        end
      end
      S_D_HI: begin
        if (rx_vld) begin
          wdata_d[15:8] = rx_byte;
          state_d       = S_D_LO;
        end
      end
      S_D_LO: begin
        if (rx_vld) begin
          wdata_d[7:0] = rx_byte;
          state_d      = S_WR;
        end
      end
      S_WR: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - 17'd1;
        if (cnt_q == 17'd1) begin
`ifdef IM_LOADER_CKSUM_EN
          state_d = S_CK;
`else
          fin_ok  = 1'b1;
`endif
        end else begin
          state_d = S_D_HI;
        end
      end
`ifdef IM_LOADER_CKSUM_EN
      S_CK: begin
        if (rx_vld) begin
          if (rx_byte == cksum_q) fin_ok  = 1'b1;
          else                    fin_bad = 1'b1;
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) fin_bad = 1'b1;
    // A failed download keeps the CPU held; only success releases it.
    if (fin_ok) begin
      state_d = S_FIN;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      hold_d  = 1'b0;
    end
    if (fin_bad) begin
      state_d = S_FIN;
      err_d   = 1'b1;
      busy_d  = 1'b0;
    end
  end

  assign im_we    = (state_q == S_WR);
  assign im_waddr = 16'(addr_q);
  assign im_wdata = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = hold_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: frame-level model predicts writes and final flags.
module tb_im_loader;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst, start, rx_vld, lo_mark;
  logic [7:0]  rx_byte;
  logic        im_we, busy, done, err, cpu_hold;
  logic [15:0] im_waddr, im_wdata;

  im_loader #(.ADDR_W(14), .BASE_ADDR(16'h0000), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_byte(rx_byte), .rx_vld(rx_vld),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata), .busy(busy),
    .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;

  int         n_chk = 0;
  int         n_fail = 0;
  wr_t        exp_q[$];
  wr_t        act_log[$];
  logic [7:0] frm[$];
  bit         mark_q[$];
  logic       exp_ok, exp_bad;
  logic       lo_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // A write must appear exactly one cycle after each data LO byte, and only then.
  always @(negedge clk) begin
    if (!rst) begin
      chk("im_we timing", im_we, lo_prev);
      if (im_we) begin
        act_log.push_back({im_waddr, im_wdata});
        if (exp_q.size() == 0) chk("unexpected write", 1, 0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write addr", im_waddr, e.a);
          chk("write data", im_wdata, e.d);
        end
      end
      chk("waddr upper bits", im_waddr[15:14], 0);
    end
    lo_prev = rx_vld & lo_mark;
  end

  // Frame-level model: what the loader must do with the byte list in frm.
  task automatic model();
    int n, nb;
`ifdef IM_LOADER_CKSUM_EN
    logic [7:0] s;
`endif
    exp_q.delete();
    mark_q.delete();
    foreach (frm[i]) mark_q.push_back(1'b0);
    exp_ok  = 1'b0;
    exp_bad = 1'b1;
    if (frm.size() < 2) return;
    n = {16'd0, frm[0], frm[1]};
    if (n == 0) begin exp_ok = 1'b1; exp_bad = 1'b0; return; end
    if (n > (1 << 14)) return;
    for (int w = 0; w < n; w++)
      if (3 + 2*w < frm.size()) begin
        mark_q[3 + 2*w] = 1'b1;
        exp_q.push_back({16'(w), frm[2 + 2*w], frm[3 + 2*w]});
      end
    nb = 2 + 2*n;
`ifdef IM_LOADER_CKSUM_EN
    s = 8'h00;
    for (int i = 0; i < nb && i < frm.size(); i++) s = s + frm[i];
    if (frm.size() > nb) begin exp_ok = (frm[nb] == s); exp_bad = !exp_ok; end
`else
    if (frm.size() >= nb) begin exp_ok = 1'b1; exp_bad = 1'b0; end
`endif
  endtask

  task automatic add_cksum();
    logic [7:0] s;
    s = 8'h00;
    foreach (frm[i]) s = s + frm[i];
    frm.push_back(s);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit lo);
    rx_byte = b; rx_vld = 1'b1; lo_mark = lo;
    @(posedge clk); #1;
    rx_vld = 1'b0; lo_mark = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input string nm, input int hold_cyc);
    model();
    act_log.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy after start"}, busy, 1);
    chk({nm, " cpu_hold after start"}, cpu_hold, 1);
    chk({nm, " done cleared"}, done, 0);
    chk({nm, " err cleared"}, err, 0);
    foreach (frm[i]) send_byte(frm[i], mark_q[i]);
    if (hold_cyc > 0) begin
      repeat (hold_cyc) begin @(posedge clk); #1; end
      chk({nm, " still busy"}, busy, 1);
    end
    for (int i = 0; i < TMO + 20 && busy; i++) begin @(posedge clk); #1; end
    chk({nm, " busy dropped"}, busy, 0);
    chk({nm, " done"}, done, exp_ok);
    chk({nm, " err"}, err, exp_bad);
    chk({nm, " cpu_hold"}, cpu_hold, !exp_ok);
    chk({nm, " writes pending"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [31:0] v);
    if (idx < act_log.size()) chk(nm, act_log[idx], v);
    else chk({nm, " missing"}, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; rx_vld = 1'b0; lo_mark = 1'b0; rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset cpu_hold", cpu_hold, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset im_we", im_we, 0);
    chk("reset im_waddr", im_waddr, 16'h0000);
    chk("reset im_wdata", im_wdata, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Bytes while idle are dropped.
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("idle bytes busy", busy, 0);
    chk("idle bytes cpu_hold", cpu_hold, 1);

    frm = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef IM_LOADER_CKSUM_EN
    add_cksum();
`endif
    run_frame("two words", 0);
    chk("two words count", act_log.size(), 2);
    chk_log("two words w0", 0, 32'h0000_1234);
    chk_log("two words w1", 1, 32'h0001_ABCD);
    chk("two words done literal", done, 1);
    chk("two words cpu_hold literal", cpu_hold, 0);

    frm = {8'h00, 8'h00};
    run_frame("zero length", 0);
    chk("zero length writes", act_log.size(), 0);

    frm = {8'h40, 8'h01};
    run_frame("too long", 0);
    chk("too long writes", act_log.size(), 0);
    chk("too long err literal", err, 1);

    frm = {8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h01};
`ifdef IM_LOADER_CKSUM_EN
    add_cksum();
`endif
    run_frame("three words", 0);
    chk_log("three words w2", 2, 32'h0002_0001);

    frm = {8'h00, 8'h03, 8'h11, 8'h22};
    run_frame("timeout", TMO - 5);
    chk("timeout count", act_log.size(), 1);
    chk_log("timeout w0", 0, 32'h0000_1122);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    chk("late bytes err", err, 1);
    chk("late bytes busy", busy, 0);

    // Exactly 2^ADDR_W words is a legal length: no error until the data stalls.
    frm = {8'h40, 8'h00};
    run_frame("max length", TMO - 5);
    chk("max length writes", act_log.size(), 0);

`ifdef IM_LOADER_CKSUM_EN
    frm = {8'h00, 8'h01, 8'h12, 8'h34, 8'h47};
    run_frame("cksum ok", 0);
    chk("cksum ok done literal", done, 1);
    frm = {8'h00, 8'h01, 8'h12, 8'h34, 8'h48};
    run_frame("cksum bad", 0);
    chk("cksum bad err literal", err, 1);
    chk("cksum bad cpu_hold literal", cpu_hold, 1);
`endif

    // Reset in the middle of a download.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset cpu_hold", cpu_hold, 1);
    chk("mid reset done", done, 0);
    chk("mid reset err", err, 0);
    chk("mid reset im_wdata", im_wdata, 16'h0000);
    chk("mid reset im_waddr", im_waddr, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time programmer for the 16-bit instruction memory; it is the write side of the memory that the fetch path reads.
- Takes a byte stream from the UART receiver, assembles it big-endian into 16-bit instructions, and drives the instruction-memory write port at sequential addresses.
- Holds the CPU in reset while a download is in progress, then releases it.

Parameters:
- ADDR_W, 14, instruction memory address width (depth 2^ADDR_W = 16384 words)
- BASE_ADDR, 16'h0000, first word address written
- TIMEOUT, 1000000, max clk cycles allowed between consecutive bytes of an active download

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  one-cycle pulse; arms a new download
- rx_byte  input  8  received byte
- rx_vld  input  1  one-cycle strobe; rx_byte is valid this cycle
- im_we  output  1  instruction memory write enable, one cycle per word
- im_waddr  output  16  word address; bits above ADDR_W are always 0
- im_wdata  output  16  instruction word
- busy  output  1  download in progress
- done  output  1  sticky; download completed
- err  output  1  sticky; download aborted
- cpu_hold  output  1  CPU reset/stall request

Behaviour:
- Reset (async, rst=1) values: state IDLE; im_we=0, im_waddr=BASE_ADDR, im_wdata=0, busy=0, done=0, err=0, cpu_hold=1.
- Frame format: LEN_HI, LEN_LO (word count N, 16 bit), then N words, each sent as HI byte then LO byte.
- States: IDLE, LEN_HI, LEN_LO, D_HI, D_LO, WR, FIN. Transitions:
  - IDLE: start -> LEN_HI; clear done/err; busy=1; cpu_hold=1.
  - LEN_HI: rx_vld -> latch N[15:8] -> LEN_LO.
  - LEN_LO: rx_vld -> latch N[7:0]. Then:
    - N=0 -> FIN with done=1.
    - N > 2^ADDR_W -> FIN with err=1; nothing written.
    - otherwise -> D_HI.
  - D_HI: rx_vld -> im_wdata[15:8] <= byte -> D_LO.
  - D_LO: rx_vld -> im_wdata[7:0] <= byte -> WR.
  - WR: im_we=1 for exactly this one cycle with the current im_waddr/im_wdata. Next cycle: im_waddr+1 and remaining-word count -1. If the count reaches 0 -> FIN with done=1; else -> D_HI.
  - FIN: busy=0; cpu_hold=0 if done, stays 1 if err; -> IDLE.
- rx_vld in IDLE, WR or FIN: byte ignored, not buffered.
- start while busy: ignored.
- Latency: im_we asserts exactly 1 cycle after the rx_vld of the LO byte. Data is stable in the cycle im_we is high; the memory samples on that edge.
- Addressing: no wrap past BASE_ADDR + 2^ADDR_W - 1. That case is excluded by the length check.
- Timeout: a counter clears on every rx_vld and runs in LEN_HI/LEN_LO/D_HI/D_LO. On reaching TIMEOUT -> FIN with err=1. Words already written are left in memory.
- After reset, cpu_hold stays 1 until the first successful download. A new start re-asserts cpu_hold immediately.
- Reset mid-download: all state returns to reset values at once; any partial image is left in memory.

Optional Feature:
- Macro: IM_LOADER_CKSUM_EN.
- With it defined:
  - One extra checksum byte follows the last data word; it equals the 8-bit modular sum of all LEN and data bytes.
  - New state CK is entered from WR instead of FIN when the count reaches 0.
  - CK, on rx_vld: match -> done=1; mismatch -> err=1 (cpu_hold stays 1). CK is covered by the timeout.
- Without it: no CK state; FIN follows the last WR directly.

Test Plan:
- Reset then idle -> cpu_hold=1, busy=0, done=0, im_we=0, im_waddr=0.
- start; bytes 00 02 12 34 AB CD -> im_we pulses twice: (0000,1234) then (0001,ABCD); done=1, cpu_hold=0, busy=0.
- start; bytes 00 00 -> no im_we; done=1 after LEN_LO.
- start; bytes 40 01 (N=16385) -> err=1, no writes, cpu_hold=1.
- start; bytes 00 03 11 22, then silence for TIMEOUT cycles -> exactly one write (0000,1122); err=1; later rx_vld ignored.
- IM_LOADER_CKSUM_EN: bytes 00 01 12 34 then 47 -> done=1; same frame ending in 48 -> err=1, cpu_hold=1.
